// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types and constants for the seven-segment scanner
package seven_segment_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_scan_timer.sv
// rtl/seven_segment_scanner_scan_timer.sv - loadable down-counter with terminal-count flag
module scan_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A loaded value N-1 yields exactly N cycles before the terminal count is seen and acted on.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed BCD display scanner; option SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS  = 3,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_digits,
    input  logic                          i_load,
    output logic                          o_pending,
    output logic [DIGIT_W-1:0]            o_digit,
    output logic [NUM_DIGITS-1:0]         o_digitEn,
    output logic                          o_frameDone
);

    localparam int CNT_W = $clog2(max_int(CLK_DIV, DEAD_CYCLES));
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                   state_q, state_d;
    logic [IDX_W-1:0]              index_q, index_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                          pend_v_q, pend_v_d;
    logic [DIGIT_W-1:0]            o_digit_q, o_digit_d;
    logic [NUM_DIGITS-1:0]         o_digitEn_q, o_digitEn_d;
    logic                          o_frameDone_q;

    logic                          timer_load;
    logic [CNT_W-1:0]              timer_val;
    logic                          timer_tc;
    logic                          frame_end;
    logic [DIGIT_W-1:0]            digit_sel;
    logic                          all_zero;
    logic                          lz_blank;

    scan_timer #(
        .CNT_W(CNT_W)
    ) u_scan_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .tc_o      (timer_tc)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pend_v_d   = pend_v_q;
        timer_load = 1'b0;
        timer_val  = '0;
        frame_end  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d    = BLANK;
                    index_d    = '0;
                    timer_load = 1'b1;
                    timer_val  = DEAD_LOAD;
                end
            end
            BLANK: begin
                if (!i_enable) begin
                    state_d    = IDLE;
                    index_d    = '0;
                    timer_load = 1'b1;
                end else if (timer_tc) begin
                    state_d    = DRIVE;
                    timer_load = 1'b1;
                    timer_val  = DRIVE_LOAD;
                end
            end
            DRIVE: begin
                if (!i_enable) begin
                    state_d    = IDLE;
                    index_d    = '0;
                    timer_load = 1'b1;
                end else if (timer_tc) begin
                    state_d    = BLANK;
                    timer_load = 1'b1;
                    timer_val  = DEAD_LOAD;
                    if (index_q == LAST_IDX) begin
                        index_d   = '0;
                        frame_end = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                index_d    = '0;
                timer_load = 1'b1;
            end
        endcase

        // The older pending value is promoted first so a load on the boundary cycle becomes the next pending.
        if (frame_end && pend_v_q) begin
            shadow_d = pending_q;
            pend_v_d = 1'b0;
        end
        if (i_load) begin
            if (state_q == IDLE) begin
                shadow_d = i_digits;
            end else begin
                pending_d = i_digits;
                pend_v_d  = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values so the registered outputs line up with the state register.
    always_comb begin
        digit_sel   = BLANK_CODE;
        o_digitEn_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_d == IDX_W'(k)) begin
                digit_sel = shadow_d[k*DIGIT_W +: DIGIT_W];
                if (state_d == DRIVE) begin
                    o_digitEn_d[k] = 1'b0;
                end
            end
        end

        all_zero = 1'b1;
        lz_blank = 1'b0;
`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero && (shadow_d[k*DIGIT_W +: DIGIT_W] == '0);
            if ((index_d == IDX_W'(k)) && all_zero) begin
                lz_blank = 1'b1;
            end
        end
`endif

        if ((state_d == IDLE) || lz_blank || all_zero == 1'b0 && 1'b0) begin
            o_digit_d = BLANK_CODE;
        end else begin
            o_digit_d = digit_sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            index_q       <= '0;
            shadow_q      <= {NUM_DIGITS{BLANK_CODE}};
            pending_q     <= {NUM_DIGITS{BLANK_CODE}};
            pend_v_q      <= 1'b0;
            o_digit_q     <= BLANK_CODE;
            o_digitEn_q   <= '1;
            o_frameDone_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            pend_v_q      <= pend_v_d;
            o_digit_q     <= o_digit_d;
            o_digitEn_q   <= o_digitEn_d;
            o_frameDone_q <= frame_end;
        end
    end

    assign o_pending   = pend_v_q;
    assign o_digit     = o_digit_q;
    assign o_digitEn   = o_digitEn_q;
    assign o_frameDone = o_frameDone_q;

endmodule
